inst_decode_stage: RTL
======================

// Module: inst_decode_stage
// PURPOSE
//  Registered RV32I decode stage between fetch and register-read. Accepts one 32-bit instruction per
//  cycle over valid/ready, splits fields for all six formats (R/I/S/B/U/J), sign-extends the immediate
//  to XLEN and flags illegal encodings. A 2-entry skid buffer keeps in_ready registered, so full
//  throughput holds under output backpressure.
// PARAMETERS
//  XLEN      32  width of the sign-extended immediate and the pc passthrough
//  PC_W      32  width of the pc sideband carried with each instruction
// PORTS
//  clk         in   1     clock; all state on rising edge
//  rst_n       in   1     synchronous active-low reset
//  flush       in   1     drop all buffered instructions this cycle
//  in_valid    in   1     inst_in/pc_in valid
//  in_ready    out  1     stage can accept; registered
//  inst_in     in   32    raw instruction
//  pc_in       in   PC_W  pc of inst_in
//  out_valid   out  1     decoded fields valid
//  out_ready   in   1     consumer accepts
//  out_dec     out  decode_pkg::dec_t  {pc, opcode[6:0], fmt, rd, rs1, rs2, funct3, funct7, imm[XLEN], illegal}
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): out_valid=0, in_ready=1, both entries empty, out_dec=0, counters=0.
//  - Transfer in when in_valid&in_ready; out when out_valid&out_ready. Latency 1 cycle in->out.
//  - States: EMPTY (out reg empty), ONE (out reg full), FULL (out reg + skid full). in_ready = state!=FULL.
//    EMPTY: in -> ONE. ONE: in&out -> ONE; in only -> FULL; out only -> EMPTY.
//    FULL: out -> ONE (skid moves to out reg); in_ready=0, no input accepted. Order strictly preserved.
//  - out_valid/out_dec come directly from the out register; out_dec held stable while out_valid&!out_ready.
//  - Field extraction: rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
//    Fields unused by the format drive 0 (rd for S/B; rs2 for I/U/J; rs1 for U/J; funct3 for U/J; funct7 except R).
//  - imm (sign bit inst[31], extended to XLEN): I {[31:20]}; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0};
//    U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}; R imm=0.
//  - fmt by opcode: 03/13/67 I; 23 S; 33 R; 63 B; 37/17 U; 6F J.
//  - illegal=1 if inst[1:0]!=2'b11, opcode unlisted, R-type funct7 not in {00,20},
//    or funct3 reserved for B (010,011) / LOAD (011,110,111) / STORE (>=011) / JALR (!=000).
//    Illegal instructions still flow through with fmt=R, imm=0; never dropped.
//  - flush (priority over all): next cycle state=EMPTY, out_valid=0, in_ready=1; input offered in the flush cycle is discarded.
//  - Simultaneous in and out in FULL impossible (in_ready=0). rst_n low mid-transfer: all entries discarded.
// CONFIGURATION
//  - `DECODE_PERF_CNT_EN defined: adds outputs perf_dec_cnt[31:0] (+1 per output transfer) and
//    perf_ill_cnt[31:0] (+1 per output transfer with illegal=1); both wrap at 2^32, clear on reset, unaffected by flush.
//  - Undefined: ports and counters absent; decode behaviour identical.
// STRUCTURE
//  - decode_pkg: opcode localparams (OP_LOAD..OP_JAL), inst_fmt_e enum {FMT_R,FMT_I,FMT_S,FMT_B,FMT_U,FMT_J},
//    dec_t packed struct, stage state enum.
//  - Sub-module imm_gen (combinational: inst+fmt -> XLEN imm); field split/illegal check inline; the two
//    entry registers store dec_t (decode before the skid, not after).
// TESTING
//  - 0x00812283 (lw x5,8(x2)) -> next cycle fmt=I, rd=5, rs1=2, funct3=2, imm=0x00000008, illegal=0.
//  - 0xFE512E23 (sw x5,-4(x2)) -> fmt=S, rs1=2, rs2=5, rd=0, imm=0xFFFFFFFC.
//  - 0xFE208CE3 (beq x1,x2,-8) -> fmt=B, imm=0xFFFFFFF8; 0x002081B3 (add x3,x1,x2) -> fmt=R, funct7=0, imm=0.
//  - 0xFFFFFFFF and 0x00000000 -> illegal=1, passed through in order; perf_ill_cnt +2 when enabled.
//  - out_ready=0 for 3 cycles, in_valid=1 with A,B,C: A,B accepted, in_ready=0 from cycle 2, C held;
//    out_ready=1 -> A,B,C emitted on consecutive cycles, no loss/duplication.
//  - flush while FULL and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed and offered instructions never appear.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage: opcodes, instruction formats,
// the decoded-instruction record and the skid-buffer state encoding.
package decode_pkg;

    localparam int DEC_XLEN = 32;
    localparam int DEC_PC_W = 32;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } inst_fmt_e;

    typedef struct packed {
        logic [DEC_PC_W-1:0] pc;
        logic [6:0]          opcode;
        inst_fmt_e           fmt;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [DEC_XLEN-1:0] imm;
        logic                illegal;
    } dec_t;

    // Stage occupancy: output register only, or output register plus skid entry.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: rebuilds the format-specific immediate
// from the instruction and sign-extends it from inst[31] to XLEN.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst,
    input  inst_fmt_e       fmt,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32_s;

    // Assemble the 32-bit immediate for each format; R-type carries none.
    always_comb begin
        imm32_s = 32'sd0;
        case (fmt)
            FMT_I:   imm32_s = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32_s = {inst[31:12], 12'b0};
            FMT_J:   imm32_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32_s = 32'sd0;
        endcase
    end

    assign imm = XLEN'(imm32_s);

endmodule

// File: rtl/inst_decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer (output register + skid).
// Optional performance counters are built when DECODE_PERF_CNT_EN is defined.
module inst_decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst_in,
    input  logic [PC_W-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output dec_t            out_dec
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]     perf_dec_cnt,
    output logic [31:0]     perf_ill_cnt
`endif
);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    inst_fmt_e       fmt_raw_s;
    inst_fmt_e       fmt_s;
    logic            unlisted_s;
    logic            illegal_s;
    logic [XLEN-1:0] imm_s;
    dec_t            dec_s;

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic            out_valid_r;
    logic            in_ready_r;
    dec_t            out_r;
    dec_t            skid_r;
    logic            acc_in_s;
    logic            acc_out_s;
    logic            load_out_s;
    logic            load_skid_s;
    logic            skid_to_out_s;

    assign opcode_s = inst_in[6:0];
    assign funct3_s = inst_in[14:12];
    assign funct7_s = inst_in[31:25];

    // Classify the opcode and detect reserved encodings; illegal ones decode as R with no immediate.
    always_comb begin
        fmt_raw_s  = FMT_R;
        unlisted_s = 1'b0;
        case (opcode_s)
            OP_LOAD, OP_IMM, OP_JALR: fmt_raw_s = FMT_I;
            OP_STORE:                 fmt_raw_s = FMT_S;
            OP_OP:                    fmt_raw_s = FMT_R;
            OP_BRANCH:                fmt_raw_s = FMT_B;
            OP_LUI, OP_AUIPC:         fmt_raw_s = FMT_U;
            OP_JAL:                   fmt_raw_s = FMT_J;
            default:                  unlisted_s = 1'b1;
        endcase

        illegal_s = (inst_in[1:0] != 2'b11) || unlisted_s
                 || ((opcode_s == OP_OP) && (funct7_s != 7'h00) && (funct7_s != 7'h20))
                 || ((opcode_s == OP_BRANCH) && ((funct3_s == 3'b010) || (funct3_s == 3'b011)))
                 || ((opcode_s == OP_LOAD) && ((funct3_s == 3'b011) || (funct3_s[2:1] == 2'b11)))
                 || ((opcode_s == OP_STORE) && (funct3_s >= 3'b011))
                 || ((opcode_s == OP_JALR) && (funct3_s != 3'b000));

        if (illegal_s) begin
            fmt_s = FMT_R;
        end else begin
            fmt_s = fmt_raw_s;
        end
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (inst_in[31:7]),
        .fmt  (fmt_s),
        .imm  (imm_s)
    );

    // Build the decoded record, zeroing fields the format does not use.
    always_comb begin
        dec_s         = '0;
        dec_s.pc      = pc_in;
        dec_s.opcode  = opcode_s;
        dec_s.fmt     = fmt_s;
        dec_s.imm     = imm_s;
        dec_s.illegal = illegal_s;
        dec_s.rd      = ((fmt_s == FMT_S) || (fmt_s == FMT_B)) ? 5'd0 : inst_in[11:7];
        dec_s.rs1     = ((fmt_s == FMT_U) || (fmt_s == FMT_J)) ? 5'd0 : inst_in[19:15];
        dec_s.funct3  = ((fmt_s == FMT_U) || (fmt_s == FMT_J)) ? 3'd0 : funct3_s;
        dec_s.rs2     = ((fmt_s == FMT_I) || (fmt_s == FMT_U) || (fmt_s == FMT_J)) ? 5'd0 : inst_in[24:20];
        dec_s.funct7  = (fmt_s == FMT_R) ? funct7_s : 7'd0;
    end

    assign acc_in_s  = in_valid & in_ready_r;
    assign acc_out_s = out_valid_r & out_ready;

    // Occupancy next-state; flush overrides everything and discards the offered input.
    always_comb begin
        state_nxt_s   = state_r;
        load_out_s    = 1'b0;
        load_skid_s   = 1'b0;
        skid_to_out_s = 1'b0;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_in_s) begin
                        load_out_s  = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (acc_in_s && acc_out_s) begin
                        load_out_s  = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else if (acc_in_s) begin
                        load_skid_s = 1'b1;
                        state_nxt_s = ST_FULL;
                    end else if (acc_out_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (acc_out_s) begin
                        skid_to_out_s = 1'b1;
                        state_nxt_s   = ST_ONE;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: state_nxt_s = ST_EMPTY;
            endcase
        end
    end

    // Occupancy, handshake flags and the two decoded entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            out_r       <= '0;
            skid_r      <= '0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            in_ready_r  <= (state_nxt_s != ST_FULL);
            if (load_out_s) begin
                out_r <= dec_s;
            end else if (skid_to_out_s) begin
                out_r <= skid_r;
            end else begin
                out_r <= out_r;
            end
            if (load_skid_s) begin
                skid_r <= dec_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_dec   = out_r;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_dec_cnt_r;
    logic [31:0] perf_ill_cnt_r;

    // Output-transfer counters; they survive flush and wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_dec_cnt_r <= 32'd0;
            perf_ill_cnt_r <= 32'd0;
        end else begin
            if (acc_out_s) begin
                perf_dec_cnt_r <= perf_dec_cnt_r + 32'd1;
            end else begin
                perf_dec_cnt_r <= perf_dec_cnt_r;
            end
            if (acc_out_s && out_r.illegal) begin
                perf_ill_cnt_r <= perf_ill_cnt_r + 32'd1;
            end else begin
                perf_ill_cnt_r <= perf_ill_cnt_r;
            end
        end
    end

    assign perf_dec_cnt = perf_dec_cnt_r;
    assign perf_ill_cnt = perf_ill_cnt_r;
`endif

endmodule
